// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: collects DEPTH unsigned elements, bubble-sorts them ascending with one
// shared comparator (one compare per clock), then streams them out smallest first.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (aborts any batch in progress)
//   in_valid     producer offers in_data
//   in_data      element to load (WIDTH bits)
//   in_ready     high while loading; a transfer is in_valid && in_ready
//   out_valid    out_data holds a sorted element
//   out_data     sorted element, smallest first; stable while out_valid && !out_ready
//   out_ready    consumer accepts out_data
//   busy         high while sorting
//   cmp_result   registered {gt, eq, lt} of the most recent compare
//   swap_count   number of swaps in the current/last sort (only with CMP_SORT_SWAP_COUNT_EN)
//
// Optional feature macro: CMP_SORT_SWAP_COUNT_EN adds the swap_count output and counter.
module cmp_sort_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               in_ready,
    output logic                               out_valid,
    output logic [WIDTH-1:0]                   out_data,
    input  logic                               out_ready,
    output logic                               busy,
`ifdef CMP_SORT_SWAP_COUNT_EN
    output logic [2:0]                         cmp_result,
    output logic [$clog2(DEPTH*DEPTH):0]       swap_count
`else
    output logic [2:0]                         cmp_result
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_CMP = AW'(DEPTH - 2);

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_t;

    state_t            r_state, w_next;
    logic [WIDTH-1:0]  r_buf [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr, r_idx, r_pass;
    logic              r_swapped, r_in_ready;
    logic [2:0]        r_cmp;
    logic [AW-1:0]     w_idx1;
    logic [WIDTH-1:0]  w_a, w_b;
    logic              w_gt, w_eq, w_lt;
    logic              w_in_fire, w_load_done, w_pass_end, w_sort_done, w_out_fire, w_out_done;

    assign w_idx1 = r_idx + 1'b1;
    assign w_a    = r_buf[r_idx];
    assign w_b    = r_buf[w_idx1];
    assign w_gt   = w_a > w_b;
    assign w_eq   = w_a == w_b;
    assign w_lt   = w_a < w_b;

    // r_in_ready is only ever high in LOAD, so it doubles as the load-state qualifier
    assign w_in_fire   = in_valid && r_in_ready;
    assign w_load_done = w_in_fire && r_wr_ptr == LAST;
    assign w_pass_end  = r_state == S_SORT && r_idx == LAST_CMP;
    // a swap in the final compare of a pass still counts toward "this pass swapped"
    assign w_sort_done = w_pass_end && (!(r_swapped || w_gt) || r_pass == LAST_CMP);
    assign w_out_fire  = r_state == S_OUT && out_ready;
    assign w_out_done  = w_out_fire && r_rd_ptr == LAST;

    always_comb begin
        w_next = w_load_done ? S_SORT :
                 w_sort_done ? S_OUT  :
                 w_out_done  ? S_LOAD : r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_idx      <= '0;
            r_pass     <= '0;
            r_swapped  <= 1'b0;
            r_cmp      <= 3'b000;
        end else begin
            r_in_ready <= w_next == S_LOAD;
            if (w_in_fire) r_wr_ptr <= w_load_done ? '0 : r_wr_ptr + 1'b1;
            if (w_load_done) begin
                r_idx     <= '0;
                r_pass    <= '0;
                r_swapped <= 1'b0;
            end
            if (r_state == S_SORT) begin
                r_cmp <= {w_gt, w_eq, w_lt};
                if (w_sort_done) begin
                    r_rd_ptr <= '0;
                end else if (w_pass_end) begin
                    r_pass    <= r_pass + 1'b1;
                    r_idx     <= '0;
                    r_swapped <= 1'b0;
                end else begin
                    r_idx     <= w_idx1;
                    r_swapped <= r_swapped | w_gt;
                end
            end
            if (w_out_fire) r_rd_ptr <= w_out_done ? '0 : r_rd_ptr + 1'b1;
        end
    end

    // element storage carries no reset: its contents are meaningless until reloaded
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf[r_wr_ptr] <= in_data;
        end else if (r_state == S_SORT && w_gt) begin
            r_buf[r_idx]  <= w_b;
            r_buf[w_idx1] <= w_a;
        end
    end

`ifdef CMP_SORT_SWAP_COUNT_EN
    logic [$clog2(DEPTH*DEPTH):0] r_swap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           r_swap_cnt <= '0;
        else if (w_load_done)                 r_swap_cnt <= '0;
        else if (r_state == S_SORT && w_gt)   r_swap_cnt <= r_swap_cnt + 1'b1;
    end

    assign swap_count = r_swap_cnt;
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = r_state == S_OUT;
    assign out_data   = out_valid ? r_buf[r_rd_ptr] : '0;
    assign busy       = r_state == S_SORT;
    assign cmp_result = r_cmp;
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb_cmp_sort_ctrl: randomized and directed batches checked against a plain bubble-sort reference.
module tb_cmp_sort_ctrl;
    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] out_data;
    logic [2:0]   cmp_result;
`ifdef CMP_SORT_SWAP_COUNT_EN
    logic [$clog2(D*D):0] swap_count;
`endif

    always #5 clk = ~clk;

    cmp_sort_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .busy(busy),
`ifdef CMP_SORT_SWAP_COUNT_EN
        .cmp_result(cmp_result),
        .swap_count(swap_count)
`else
        .cmp_result(cmp_result)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int vals[D];
    int exp_q[$];
    int exp_cmp[$];
    int exp_cyc, exp_sw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // textbook bubble sort with early exit; records each compare outcome and the swap total
    task automatic model();
        int a[D];
        int t;
        bit any;
        a = vals;
        exp_cmp.delete();
        exp_q.delete();
        exp_cyc = 0;
        exp_sw = 0;
        for (int p = 0; p < D - 1; p++) begin
            any = 0;
            for (int i = 0; i < D - 1; i++) begin
                exp_cyc++;
                exp_cmp.push_back(a[i] > a[i+1] ? 4 : a[i] == a[i+1] ? 2 : 1);
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                    any = 1;
                    exp_sw++;
                end
            end
            if (!any) break;
        end
        for (int i = 0; i < D; i++) exp_q.push_back(a[i]);
    endtask

    task automatic load(input bit gaps);
        int t;
        for (int k = 0; k < D; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid  = 1'b1;
            in_data   = W'(vals[k]);
            out_ready = 1'($urandom_range(0, 1));
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) check("load_timeout", 0, 1);
            @(negedge clk);
            in_valid = 1'b0;
        end
        out_ready = 1'b0;
    endtask

    task automatic sort_drain(input int stall);
        int n, bad, s;
        int obs[$];
        model();
        check("in_ready_drop", in_ready, 0);
        check("busy_rise", busy, 1);
        n = 0;
        in_valid = 1'b1;
        while (busy && n < 100) begin
            in_data = W'($urandom_range(0, 15));
            @(negedge clk);
            n++;
            obs.push_back(int'(cmp_result));
        end
        in_valid = 1'b0;
        check("sort_cycles", n, exp_cyc);
        bad = 0;
        for (int i = 0; i < obs.size() && i < exp_cmp.size(); i++) if (obs[i] != exp_cmp[i]) bad++;
        check("cmp_seq_mismatches", bad, 0);
`ifdef CMP_SORT_SWAP_COUNT_EN
        check("swap_count", swap_count, exp_sw);
`endif
        for (int k = 0; k < D; k++) begin
            s = (k == 0) ? stall : $urandom_range(0, 2);
            repeat (s) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, exp_q[k]);
                check("stall_in_ready", in_ready, 0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            check("out_valid", out_valid, 1);
            check("out_data", out_data, exp_q[k]);
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("out_done_valid", out_valid, 0);
        check("out_done_in_ready", in_ready, 1);
        check("out_done_busy", busy, 0);
`ifdef CMP_SORT_SWAP_COUNT_EN
        check("swap_count_hold", swap_count, exp_sw);
`endif
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cmp", cmp_result, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        vals = '{9, 3, 7, 1};   load(0); sort_drain(0);
        vals = '{1, 2, 3, 4};   load(1); sort_drain(0);
        vals = '{4, 3, 2, 1};   load(0); sort_drain(1);
        vals = '{15, 0, 15, 0}; load(0); sort_drain(0);
        vals = '{5, 5, 5, 5};   load(0); sort_drain(0);
        check("eq_cmp_result", cmp_result, 3'b010);
        vals = '{6, 2, 8, 4};   load(0); sort_drain(5);

        vals = '{4, 3, 2, 1};
        load(0);
        repeat (4) @(negedge clk);
        check("mid_sort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_in_ready", in_ready, 1);
        check("rerst_out_valid", out_valid, 0);
        vals = '{3, 1, 2, 0};   load(0); sort_drain(2);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < D; i++) vals[i] = $urandom_range(0, 15);
            load(1);
            sort_drain($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
- Collects DEPTH unsigned values, sorts them into ascending order, then streams them out.
- Uses one shared magnitude-compare path, time-multiplexed as a bubble sort at one compare per clock.
- Sits between a valid/ready producer and a valid/ready consumer.
- Provides the sequencing layer that turns the team's combinational gt/eq/lt comparator into a usable sort resource.

Parameters:
- WIDTH, 4, bit width of each data element.
- DEPTH, 4, number of elements per sort batch (legal range 2 to 16).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has an element on in_data.
- in_data  input  WIDTH  element to load.
- in_ready  output  1  block accepts an element this cycle.
- out_valid  output  1  out_data holds a sorted element.
- out_data  output  WIDTH  sorted element, smallest first.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  high while in SORT.
- cmp_result  output  3  {gt, eq, lt} of the current compare, registered, for debug.

Interface decision:
- One clock (clk).
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Storage: buf[0..DEPTH-1] of WIDTH bits.
  - wr_ptr and rd_ptr are clog2(DEPTH) bits.
  - idx (compare index) and pass counter are sized to their ranges.
  - swapped_flag is 1 bit.
- Reset (rst_n low, asynchronous):
  - state = LOAD; all pointers and counters = 0; swapped_flag = 0.
  - in_ready = 0 during reset, 1 in the first cycle after release.
  - out_valid = 0, out_data = 0, busy = 0, cmp_result = 3'b000.
  - buf contents don't-care.
  - Reset asserted mid-operation aborts the batch; no partial output is emitted afterwards.
- State LOAD:
  - in_ready = 1.
  - A transfer occurs on in_valid && in_ready: buf[wr_ptr] <= in_data, wr_ptr increments.
  - On the DEPTH-th transfer: wr_ptr <= 0, idx <= 0, pass <= 0, swapped_flag <= 0, next state SORT.
  - in_ready drops the cycle after the last transfer.
- State SORT:
  - busy = 1, in_ready = 0, out_valid = 0.
  - Each cycle compares a = buf[idx] and b = buf[idx+1], unsigned.
    - gt = a>b, eq = a==b, lt = a<b; exactly one bit is set.
    - cmp_result <= {gt, eq, lt}.
  - If gt: swap buf[idx] and buf[idx+1] in the same edge; swapped_flag <= 1.
  - eq or lt: no swap. Equal elements are never swapped, so the sort is stable.
  - idx increments each cycle.
  - At the end of a pass (idx == DEPTH-2):
    - If swapped_flag (including the current cycle's swap) is 0, or pass == DEPTH-2: next state OUT, rd_ptr <= 0.
    - Otherwise: pass++, idx <= 0, swapped_flag <= 0.
  - Cycle count in SORT:
    - Already-sorted input: DEPTH-1 cycles (early exit).
    - Worst case: (DEPTH-1)^2 cycles.
- State OUT:
  - out_valid = 1, out_data = buf[rd_ptr] (registered/stable while out_valid && !out_ready).
  - A transfer occurs on out_valid && out_ready: rd_ptr increments.
  - After the transfer of element DEPTH-1: out_valid <= 0, next state LOAD, in_ready <= 1.
  - No overlap between OUT and LOAD: in_ready is 0 throughout OUT.
- Boundaries:
  - in_valid while not in LOAD is ignored (no write).
  - out_ready while out_valid = 0 has no effect.
  - Value 0 and value 2^WIDTH-1 compare correctly; there is no signed interpretation.

Optional Feature:
- Macro: CMP_SORT_SWAP_COUNT_EN.
- When defined:
  - Adds output port swap_count, width clog2(DEPTH*DEPTH)+1.
  - Cleared on reset and on entry to SORT.
  - Increments on every gt swap.
  - Holds its value through OUT until the next SORT entry.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Load 9,3,7,1 (DEPTH=4) -> SORT lasts 9 cycles; out_data sequence 1,3,7,9; swap_count = 5 when the macro is defined.
- Load 1,2,3,4 -> busy high exactly 3 cycles (early exit); output 1,2,3,4; swap_count = 0.
- Load 4,3,2,1 -> busy high 9 cycles; output 1,2,3,4; swap_count = 6.
- Load 15,0,15,0 plus the equal-values case 5,5,5,5 -> outputs 0,0,15,15 and 5,5,5,5; cmp_result shows 3'b010 on every compare of the 5s.
- Load 6,2,8,4 with out_ready low for 5 cycles after out_valid rises -> out_data holds 2 and no element is lost or duplicated; output 2,4,6,8; in_ready stays 0 until the last element transfers.
- Assert rst_n low during SORT (second pass), release, then load 3,1,2,0 -> outputs reset to the values above, and the next batch outputs 0,1,2,3 with no leftover elements.
